c7bbiu_rdarb: RTL and testbench



---
 rtl/c7bbiu_rdarb_if.sv | 39 +++
 rtl/c7bbiu_rdarb.sv | 146 ++++++++++++++
 tb/tb_c7bbiu_rdarb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/c7bbiu_rdarb_if.sv
// c7bbiu_rdarb_if: channel-side and BIU-side read bus of the read arbiter.
//  Parameters: NCH channels, AW address width, DW data width, GW grant id width.
//  Channel side: ch_rd_req/ch_rd_addr in; ch_rd_ack/ch_data_valid/ch_data_last/ch_data out.
//  BIU side:     biu_rd_req/biu_rd_addr out; biu_rd_ack/biu_data_valid/biu_data in.
//  Status:       busy, grant_id, arb_err out.
//  modport slave is the arbiter's view; modport master is the surrounding core/BIU view.
interface c7bbiu_rdarb_if #(
  parameter int unsigned NCH = 2,
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 64,
  parameter int unsigned GW  = (NCH > 1) ? $clog2(NCH) : 1
);
  logic [NCH-1:0]    ch_rd_req;
  logic [NCH*AW-1:0] ch_rd_addr;
  logic [NCH-1:0]    ch_rd_ack;
  logic [NCH-1:0]    ch_data_valid;
  logic              ch_data_last;
  logic [DW-1:0]     ch_data;
  logic              biu_rd_req;
  logic [AW-1:0]     biu_rd_addr;
  logic              biu_rd_ack;
  logic              biu_data_valid;
  logic [DW-1:0]     biu_data;
  logic              busy;
  logic [GW-1:0]     grant_id;
  logic              arb_err;

  modport slave (
    input  ch_rd_req, ch_rd_addr, biu_rd_ack, biu_data_valid, biu_data,
    output ch_rd_ack, ch_data_valid, ch_data_last, ch_data,
           biu_rd_req, biu_rd_addr, busy, grant_id, arb_err
  );

  modport master (
    output ch_rd_req, ch_rd_addr, biu_rd_ack, biu_data_valid, biu_data,
    input  ch_rd_ack, ch_data_valid, ch_data_last, ch_data,
           biu_rd_req, biu_rd_addr, busy, grant_id, arb_err
  );
endinterface

// File: rtl/c7bbiu_rdarb.sv
// c7bbiu_rdarb: N-channel round-robin read arbiter in front of the single BIU read port.
//  One read outstanding at a time, BEATS data beats per read, ack/data routed to the granted channel.
//  Ports: clk, reset (synchronous, active high), bus (c7bbiu_rdarb_if.slave).
module c7bbiu_rdarb #(
  parameter int unsigned NCH   = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned BEATS = 1
) (
  input logic           clk,
  input logic           reset,
  c7bbiu_rdarb_if.slave bus
);
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t         state, state_d;
  logic [GW-1:0]  rr_ptr, rr_ptr_d;
  logic [GW-1:0]  grant_id, grant_id_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [BW-1:0]  beat_cnt, beat_cnt_d;
  logic           arb_err_q, arb_err_d;

  logic           pick_vld;
  logic [GW-1:0]  pick_id;
  logic [AW-1:0]  pick_addr;
  logic [NCH-1:0] grant_oh;
  logic [NCH-1:0] ack_c;
  logic [NCH-1:0] dv_c;
  logic           last_c;
  logic           last_beat;

  // Round-robin pick: requesters at or above rr_ptr win over those below it, lowest index first
  // within each segment. Descending loops let the later, higher-priority assignment stick.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (bus.ch_rd_req[i] && (i < int'(rr_ptr))) begin
        pick_vld = 1'b1;
        pick_id  = GW'(i);
      end
    end
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (bus.ch_rd_req[i] && (i >= int'(rr_ptr))) begin
        pick_vld = 1'b1;
        pick_id  = GW'(i);
      end
    end
  end

  // Address of the picked channel.
  always_comb begin
    pick_addr = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (pick_id == GW'(i)) pick_addr = bus.ch_rd_addr[i*AW +: AW];
    end
  end

  // One-hot of the registered grant; used to steer ack and data strobes.
  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      grant_oh[i] = (grant_id == GW'(i));
    end
  end

  assign last_beat = (beat_cnt == BW'(BEATS - 1));

  // Next state and combinational channel strobes.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    grant_id_d = grant_id;
    addr_d     = addr_q;
    beat_cnt_d = beat_cnt;
    arb_err_d  = bus.biu_data_valid && (state != DATA);
    ack_c      = '0;
    dv_c       = '0;
    last_c     = 1'b0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick_id;
          addr_d     = pick_addr;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus.biu_rd_ack) begin
          ack_c      = grant_oh;
          rr_ptr_d   = (grant_id == GW'(NCH - 1)) ? '0 : grant_id + GW'(1);
          beat_cnt_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bus.biu_data_valid) begin
          dv_c = grant_oh;
          if (last_beat) begin
            last_c  = 1'b1;
            state_d = IDLE;
          end else begin
            beat_cnt_d = beat_cnt + BW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_id  <= '0;
      addr_q    <= '0;
      beat_cnt  <= '0;
      arb_err_q <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      grant_id  <= grant_id_d;
      addr_q    <= addr_d;
      beat_cnt  <= beat_cnt_d;
      arb_err_q <= arb_err_d;
    end
  end

  assign bus.ch_rd_ack     = ack_c;
  assign bus.ch_data_valid = dv_c;
  assign bus.ch_data_last  = last_c;
  assign bus.ch_data       = bus.biu_data;
  assign bus.biu_rd_req    = (state == REQ);
  assign bus.biu_rd_addr   = addr_q;
  assign bus.busy          = (state != IDLE);
  assign bus.grant_id      = grant_id;
  assign bus.arb_err       = arb_err_q;
endmodule

// File: tb/tb_c7bbiu_rdarb.sv
// tb_c7bbiu_rdarb: directed bench for c7bbiu_rdarb.
//  u_dut_a: NCH=2 BEATS=1, u_dut_b: NCH=2 BEATS=4, u_dut_c: NCH=3 BEATS=1.
//  Inputs change and outputs are sampled on the falling clock edge.
module tb_c7bbiu_rdarb;
  logic clk;
  logic ra, rb, rc;
  int   n_cmp = 0;
  int   n_err = 0;

  c7bbiu_rdarb_if #(.NCH(2)) ifa ();
  c7bbiu_rdarb_if #(.NCH(2)) ifb ();
  c7bbiu_rdarb_if #(.NCH(3)) ifc ();

  c7bbiu_rdarb #(.NCH(2), .BEATS(1)) u_dut_a (.clk(clk), .reset(ra), .bus(ifa));
  c7bbiu_rdarb #(.NCH(2), .BEATS(4)) u_dut_b (.clk(clk), .reset(rb), .bus(ifb));
  c7bbiu_rdarb #(.NCH(3), .BEATS(1)) u_dut_c (.clk(clk), .reset(rc), .bus(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Full single-beat read on dut A; requests already driven and A in IDLE.
  task automatic a_xact(input logic [1:0] m, input logic [63:0] gid,
                        input logic [31:0] addr, input logic [63:0] d);
    tick();
    chk("a_req", 64'(ifa.biu_rd_req), 64'd1);
    chk("a_gid", 64'(ifa.grant_id), gid);
    chk("a_addr", 64'(ifa.biu_rd_addr), 64'(addr));
    chk("a_noack", 64'(ifa.ch_rd_ack), 64'd0);
    ifa.biu_rd_ack = 1'b1;
    #1;
    chk("a_ack", 64'(ifa.ch_rd_ack), 64'(m));
    tick();
    ifa.biu_rd_ack = 1'b0;
    ifa.ch_rd_req  = ifa.ch_rd_req & ~m;
    ifa.biu_data_valid = 1'b1;
    ifa.biu_data = d;
    #1;
    chk("a_dv", 64'(ifa.ch_data_valid), 64'(m));
    chk("a_last", 64'(ifa.ch_data_last), 64'd1);
    chk("a_data", ifa.ch_data, d);
    tick();
    ifa.biu_data_valid = 1'b0;
    #1;
    chk("a_idle", 64'(ifa.busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ra = 1'b1; rb = 1'b1; rc = 1'b1;
    ifa.ch_rd_req = '0; ifa.ch_rd_addr = '0; ifa.biu_rd_ack = 1'b0;
    ifa.biu_data_valid = 1'b0; ifa.biu_data = '0;
    ifb.ch_rd_req = '0; ifb.ch_rd_addr = '0; ifb.biu_rd_ack = 1'b0;
    ifb.biu_data_valid = 1'b0; ifb.biu_data = '0;
    ifc.ch_rd_req = '0; ifc.ch_rd_addr = '0; ifc.biu_rd_ack = 1'b0;
    ifc.biu_data_valid = 1'b0; ifc.biu_data = '0;
    tick();
    tick();
    ra = 1'b0; rb = 1'b0; rc = 1'b0;

    // reset state
    #1;
    chk("rst_busy", 64'(ifa.busy), 64'd0);
    chk("rst_req", 64'(ifa.biu_rd_req), 64'd0);
    chk("rst_gid", 64'(ifa.grant_id), 64'd0);
    chk("rst_addr", 64'(ifa.biu_rd_addr), 64'd0);
    chk("rst_err", 64'(ifa.arb_err), 64'd0);
    chk("rst_dv", 64'(ifa.ch_data_valid), 64'd0);
    chk("rst_busy_c", 64'(ifc.busy), 64'd0);

    // T1: single read from ch0, BIU ack two cycles after the request
    ifa.ch_rd_req  = 2'b01;
    ifa.ch_rd_addr = {32'h0, 32'h1c000000};
    #1;
    chk("t1_req_lat", 64'(ifa.biu_rd_req), 64'd0);
    tick();
    chk("t1_req", 64'(ifa.biu_rd_req), 64'd1);
    chk("t1_addr", 64'(ifa.biu_rd_addr), 64'h1c000000);
    chk("t1_busy", 64'(ifa.busy), 64'd1);
    tick();
    chk("t1_noack", 64'(ifa.ch_rd_ack), 64'd0);
    ifa.biu_rd_ack = 1'b1;
    #1;
    chk("t1_ack", 64'(ifa.ch_rd_ack), 64'd1);
    tick();
    ifa.biu_rd_ack = 1'b0;
    ifa.ch_rd_req  = 2'b00;
    ifa.biu_data_valid = 1'b1;
    ifa.biu_data = 64'h1122334455667788;
    #1;
    chk("t1_req_drop", 64'(ifa.biu_rd_req), 64'd0);
    chk("t1_dv", 64'(ifa.ch_data_valid), 64'd1);
    chk("t1_last", 64'(ifa.ch_data_last), 64'd1);
    chk("t1_data", ifa.ch_data, 64'h1122334455667788);
    tick();
    ifa.biu_data_valid = 1'b0;
    #1;
    chk("t1_busy_fall", 64'(ifa.busy), 64'd0);
    chk("t1_dv_off", 64'(ifa.ch_data_valid), 64'd0);

    // T2: both channels from reset, round-robin order 0, 1, 0
    ra = 1'b1;
    tick();
    ra = 1'b0;
    ifa.ch_rd_req  = 2'b11;
    ifa.ch_rd_addr = {32'h2000, 32'h1000};
    a_xact(2'b01, 64'd0, 32'h1000, 64'haaaa0001);
    a_xact(2'b10, 64'd1, 32'h2000, 64'haaaa0002);
    ifa.ch_rd_req = 2'b11;
    a_xact(2'b01, 64'd0, 32'h1000, 64'haaaa0003);

    // T4: stray BIU beat in IDLE
    ifa.ch_rd_req = 2'b00;
    ifa.biu_data_valid = 1'b1;
    ifa.biu_data = 64'hdead;
    #1;
    chk("t4_dv", 64'(ifa.ch_data_valid), 64'd0);
    tick();
    ifa.biu_data_valid = 1'b0;
    #1;
    chk("t4_err", 64'(ifa.arb_err), 64'd1);
    chk("t4_busy", 64'(ifa.busy), 64'd0);
    chk("t4_req", 64'(ifa.biu_rd_req), 64'd0);
    tick();
    chk("t4_err_off", 64'(ifa.arb_err), 64'd0);

    // T3: four-beat burst to ch1 with one-cycle gaps; ch0 requests during the last beat
    ifb.ch_rd_req  = 2'b10;
    ifb.ch_rd_addr = {32'h3000, 32'h0};
    tick();
    chk("t3_gid", 64'(ifb.grant_id), 64'd1);
    chk("t3_addr", 64'(ifb.biu_rd_addr), 64'h3000);
    ifb.biu_rd_ack = 1'b1;
    #1;
    chk("t3_ack", 64'(ifb.ch_rd_ack), 64'b10);
    tick();
    ifb.biu_rd_ack = 1'b0;
    ifb.ch_rd_req  = 2'b00;
    for (int b = 1; b <= 4; b++) begin
      ifb.biu_data_valid = 1'b1;
      ifb.biu_data = 64'(b);
      if (b == 4) begin
        ifb.ch_rd_req  = 2'b01;
        ifb.ch_rd_addr = {32'h3000, 32'h5000};
      end
      #1;
      chk("t3_dv", 64'(ifb.ch_data_valid), 64'b10);
      chk("t3_last", 64'(ifb.ch_data_last), (b == 4) ? 64'd1 : 64'd0);
      chk("t3_data", ifb.ch_data, 64'(b));
      tick();
      ifb.biu_data_valid = 1'b0;
      #1;
      chk("t3_gap_dv", 64'(ifb.ch_data_valid), 64'd0);
      if (b < 4) begin
        chk("t3_busy", 64'(ifb.busy), 64'd1);
        tick();
      end
    end
    chk("t3_idle", 64'(ifb.busy), 64'd0);
    chk("t3_no_early", 64'(ifb.biu_rd_req), 64'd0);
    tick();
    chk("t3_regrant", 64'(ifb.biu_rd_req), 64'd1);
    chk("t3_regrant_id", 64'(ifb.grant_id), 64'd0);
    chk("t3_regrant_addr", 64'(ifb.biu_rd_addr), 64'h5000);

    // T5: reset after beat 2 of the ch0 burst; beats 3 and 4 become stray
    ifb.biu_rd_ack = 1'b1;
    #1;
    chk("t5_ack", 64'(ifb.ch_rd_ack), 64'b01);
    tick();
    ifb.biu_rd_ack = 1'b0;
    ifb.ch_rd_req  = 2'b00;
    ifb.biu_data_valid = 1'b1;
    ifb.biu_data = 64'ha1;
    #1;
    chk("t5_dv1", 64'(ifb.ch_data_valid), 64'b01);
    tick();
    ifb.biu_data = 64'ha2;
    #1;
    chk("t5_dv2", 64'(ifb.ch_data_valid), 64'b01);
    chk("t5_last2", 64'(ifb.ch_data_last), 64'd0);
    tick();
    ifb.biu_data_valid = 1'b0;
    rb = 1'b1;
    tick();
    rb = 1'b0;
    #1;
    chk("t5_busy", 64'(ifb.busy), 64'd0);
    chk("t5_req", 64'(ifb.biu_rd_req), 64'd0);
    chk("t5_rr", 64'(u_dut_b.rr_ptr), 64'd0);
    chk("t5_gid", 64'(ifb.grant_id), 64'd0);
    ifb.biu_data_valid = 1'b1;
    ifb.biu_data = 64'ha3;
    #1;
    chk("t5_dv3", 64'(ifb.ch_data_valid), 64'd0);
    tick();
    ifb.biu_data = 64'ha4;
    #1;
    chk("t5_err3", 64'(ifb.arb_err), 64'd1);
    chk("t5_dv4", 64'(ifb.ch_data_valid), 64'd0);
    tick();
    ifb.biu_data_valid = 1'b0;
    #1;
    chk("t5_err4", 64'(ifb.arb_err), 64'd1);
    tick();
    chk("t5_err_off", 64'(ifb.arb_err), 64'd0);
    chk("t5_idle", 64'(ifb.busy), 64'd0);

    // T6: NCH=3, ch0 and ch2 request continuously; grants alternate 0, 2, 0, 2
    ifc.ch_rd_req  = 3'b101;
    ifc.ch_rd_addr = {32'h6000, 32'h0, 32'h4000};
    for (int k = 0; k < 4; k++) begin
      logic [2:0]  m;
      logic [63:0] g;
      logic [63:0] a;
      g = (k % 2 == 0) ? 64'd0 : 64'd2;
      m = (k % 2 == 0) ? 3'b001 : 3'b100;
      a = (k % 2 == 0) ? 64'h4000 : 64'h6000;
      tick();
      chk("t6_req", 64'(ifc.biu_rd_req), 64'd1);
      chk("t6_gid", 64'(ifc.grant_id), g);
      chk("t6_addr", 64'(ifc.biu_rd_addr), a);
      ifc.biu_rd_ack = 1'b1;
      #1;
      chk("t6_ack", 64'(ifc.ch_rd_ack), 64'(m));
      tick();
      ifc.biu_rd_ack = 1'b0;
      ifc.biu_data_valid = 1'b1;
      ifc.biu_data = 64'(k + 16);
      #1;
      chk("t6_dv", 64'(ifc.ch_data_valid), 64'(m));
      tick();
      ifc.biu_data_valid = 1'b0;
      #1;
      chk("t6_idle", 64'(ifc.busy), 64'd0);
    end
    ifc.ch_rd_req = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
